// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
//   state_t      : arbiter FSM states
//   OWN_IF/OWN_D : owner encoding of the in-flight access
//   DEF_ADDR_W/DEF_DATA_W : default memory geometry (1024x16)
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: data-priority request select with fetch anti-starvation counter
//   clka, rst_n   : clock, synchronous active-low reset
//   i_idle        : arbiter can accept a request this cycle
//   i_if_valid    : fetch request pending
//   i_d_valid     : data request pending
//   grant_if      : fetch granted (doubles as if_req_ready)
//   grant_d       : data granted (doubles as d_req_ready)
module mem_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clka,
    input  logic rst_n,
    input  logic i_idle,
    input  logic i_if_valid,
    input  logic i_d_valid,
    output logic grant_if,
    output logic grant_d
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_cnt;
    logic          w_force;
    assign w_force  = (r_cnt == CW'(STARVE_LIMIT)) && i_if_valid;
    assign grant_d  = i_idle && i_d_valid && !w_force;
    assign grant_if = i_idle && i_if_valid && (w_force || !i_d_valid);
    // A grant is always a handshake because ready mirrors valid here
    always_ff @(posedge clka) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (grant_if)
            r_cnt <= '0;
        else if (grant_d)
            r_cnt <= !i_if_valid ? '0 : (r_cnt == CW'(STARVE_LIMIT)) ? r_cnt : r_cnt + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes fetch and load/store accesses onto one synchronous RAM port
//   clka, rst_n                : clock (shared with RAM), synchronous active-low reset
//   if_req_*/if_rsp_*          : fetch request / read-data response handshakes
//   d_req_*/d_rsp_*            : load/store request / response handshakes (store ack data = 0)
//   mem_we/mem_addr/mem_din    : RAM write enable, address, write data
//   mem_dout                   : RAM read data, valid READ_LATENCY cycles after address sample
//   busy                       : arbiter is not idle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);
    state_t            r_state, w_next;
    logic              r_owner, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_data, r_d_data;
    logic [1:0]        r_wait;
    logic              w_grant_if, w_grant_d, w_accept, w_rsp_hs;

    mem_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clka      (clka),
        .rst_n     (rst_n),
        .i_idle    (r_state == IDLE),
        .i_if_valid(if_req_valid),
        .i_d_valid (d_req_valid),
        .grant_if  (w_grant_if),
        .grant_d   (w_grant_d)
    );

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;
    assign w_accept     = w_grant_if || w_grant_d;
    assign w_rsp_hs     = (r_owner == OWN_D) ? d_rsp_ready : if_rsp_ready;
    // Latched request is only reloaded on a handshake, so the RAM bus holds its last access
    assign mem_addr     = r_addr;
    assign mem_din      = r_wdata;
    assign if_rsp_data  = r_if_data;
    assign d_rsp_data   = r_d_data;

    always_ff @(posedge clka) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ACCESS : IDLE;
            ACCESS:  w_next = r_we ? RESP : WAIT;
            WAIT:    w_next = (r_wait == '0) ? RESP : WAIT;
            RESP:    w_next = w_rsp_hs ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // rst_n gating keeps a write from landing in the RAM on the reset cycle itself
    always_comb begin
        mem_we       = (r_state == ACCESS) && r_we && rst_n;
        if_rsp_valid = (r_state == RESP) && (r_owner == OWN_IF);
        d_rsp_valid  = (r_state == RESP) && (r_owner == OWN_D);
        busy         = r_state != IDLE;
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            r_owner   <= OWN_IF;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_if_data <= '0;
            r_d_data  <= '0;
            r_wait    <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_d ? OWN_D : OWN_IF;
                r_we    <= w_grant_d && d_req_we;
                r_addr  <= w_grant_d ? d_req_addr : if_req_addr;
            end
            if (w_grant_d)
                r_wdata <= d_req_wdata;
            if (r_state == ACCESS)
                r_wait <= 2'(READ_LATENCY - 1);
            else if (r_state == WAIT)
                r_wait <= r_wait - 1'b1;
            if (r_state == ACCESS && r_we)
                r_d_data <= '0;
            if (r_state == WAIT && r_wait == '0) begin
                if (r_owner == OWN_D)
                    r_d_data <= mem_dout;
                else
                    r_if_data <= mem_dout;
            end
        end
    end
endmodule
